// File: rtl/booth_mult_seq.sv
// booth_mult_seq: radix-2 Booth signed multiplier, one add/sub step per enabled clock.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH:0] a, a_n, m, m_n, sum, step;
    logic [WIDTH-1:0] q, q_n;
    logic q_1, q_1_n, done_n;
    logic [CW-1:0] count, count_n;
    logic [2*WIDTH-1:0] result_n;
    assign busy = state == CALC;
    always_comb begin
        state_n  = state;
        a_n      = a;
        q_n      = q;
        q_1_n    = q_1;
        m_n      = m;
        count_n  = count;
        result_n = result;
        done_n   = 1'b0;
        // {Q[0],q_1}=10 subtracts, 01 adds, equal bits leave A unchanged
        sum  = (q[0] & ~q_1) ? a - m : a + m;
        step = (q[0] ^ q_1) ? sum : a;
        if (state == IDLE && start) begin
            state_n = CALC;
            a_n     = '0;
            q_n     = datab;
            q_1_n   = 1'b0;
            m_n     = {dataa[WIDTH-1], dataa};
            count_n = CW'(WIDTH);
        end else if (state == CALC) begin
            a_n     = {step[WIDTH], step[WIDTH:1]};
            q_n     = {step[0], q[WIDTH-1:1]};
            q_1_n   = q[0];
            count_n = count - CW'(1);
            state_n = count == CW'(1) ? DONE : CALC;
        end else if (state == DONE) begin
            state_n  = IDLE;
            result_n = {a[WIDTH-1:0], q};
            done_n   = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            m      <= '0;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else if (ena) begin
            state  <= state_n;
            a      <= a_n;
            q      <= q_n;
            q_1    <= q_1_n;
            m      <= m_n;
            count  <= count_n;
            result <= result_n;
            done   <= done_n;
        end
    end
endmodule
